// File: rtl/cache_sram_ctrl.sv
// cache_sram_ctrl: arbitrates two requesters (A = core, B = refill) onto the
// four byte-lane SRAM cells of the cache data array and sequences each access
// with setup/sense phases for reads and write/hold phases for writes.
module cache_sram_ctrl #(
  parameter int ADDR_W = 9,
  parameter int LANES  = 4,
  parameter bit RR_EN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [ADDR_W-1:0]       a_addr,
  input  logic [LANES-1:0]        a_be,
  input  logic [8*LANES-1:0]      a_wdata,
  output logic                    a_gnt,
  output logic                    a_rvalid,
  output logic                    a_wdone,
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [ADDR_W-1:0]       b_addr,
  input  logic [LANES-1:0]        b_be,
  input  logic [8*LANES-1:0]      b_wdata,
  output logic                    b_gnt,
  output logic                    b_rvalid,
  output logic                    b_wdone,
  output logic [8*LANES-1:0]      rdata,
  output logic                    busy,
  output logic [LANES*ADDR_W-1:0] cell_addr,
  output logic [8*LANES-1:0]      cell_din,
  input  logic [8*LANES-1:0]      cell_dout,
  output logic [LANES-1:0]        cell_wen,
  output logic [LANES-1:0]        cell_sense_en
);

  typedef enum logic [2:0] {
    IDLE,
    RD_SETUP,
    RD_SENSE,
    WR,
    WR_HOLD
  } state_t;

  state_t              state;
  logic                last_gnt;  // 1 = B was granted last
  logic                owner;     // 1 = B owns the access in flight
  logic [ADDR_W-1:0]   addr_reg;

  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LANES-1:0]    sel_be;
  logic [8*LANES-1:0]  sel_wdata;

  // Grant decision: only while idle and out of reset; ties go round-robin or to B.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (state == IDLE && !rst) begin
      if (a_req && b_req) begin
        if (RR_EN) begin
          a_gnt = last_gnt;
          b_gnt = !last_gnt;
        end else begin
          b_gnt = 1'b1;
        end
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  // Select the request fields of whichever port is being granted.
  always_comb begin
    sel_we    = b_gnt ? b_we    : a_we;
    sel_addr  = b_gnt ? b_addr  : a_addr;
    sel_be    = b_gnt ? b_be    : a_be;
    sel_wdata = b_gnt ? b_wdata : a_wdata;
  end

  // Every lane sees the same word address; it is a direct register output.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_addr
      assign cell_addr[gi*ADDR_W +: ADDR_W] = addr_reg;
    end
  endgenerate

  // Access sequencer with registered SRAM controls and response pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_gnt      <= 1'b1;
      owner         <= 1'b0;
      busy          <= 1'b0;
      addr_reg      <= '0;
      cell_din      <= '0;
      cell_wen      <= '0;
      cell_sense_en <= '0;
      rdata         <= '0;
      a_rvalid      <= 1'b0;
      b_rvalid      <= 1'b0;
      a_wdone       <= 1'b0;
      b_wdone       <= 1'b0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_wdone  <= 1'b0;
      b_wdone  <= 1'b0;
      case (state)
        IDLE: begin
          if (a_gnt || b_gnt) begin
            owner    <= b_gnt;
            last_gnt <= b_gnt;
            busy     <= 1'b1;
            addr_reg <= sel_addr;
            if (sel_we) begin
              cell_din <= sel_wdata;
              cell_wen <= sel_be;
              state    <= WR;
            end else begin
              state    <= RD_SETUP;
            end
          end
        end
        RD_SETUP: begin
          cell_sense_en <= '1;
          state         <= RD_SENSE;
        end
        RD_SENSE: begin
          rdata         <= cell_dout;
          cell_sense_en <= '0;
          a_rvalid      <= !owner;
          b_rvalid      <= owner;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        WR: begin
          cell_wen <= '0;
          a_wdone  <= !owner;
          b_wdone  <= owner;
          state    <= WR_HOLD;
        end
        WR_HOLD: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          cell_wen      <= '0;
          cell_sense_en <= '0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_sram_ctrl.sv
// Bench for cache_sram_ctrl: behavioural SRAM cells, a word-level memory
// model with an arbitration model, and a response scoreboard.
module tb_cache_sram_ctrl;
  localparam int AW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [1:0]        req, we;
  logic [AW-1:0]     addr [2];
  logic [3:0]        be [2];
  logic [31:0]       wdata [2];

  logic              a_gnt, b_gnt, a_rvalid, b_rvalid, a_wdone, b_wdone;
  logic [31:0]       rdata;
  logic              busy;
  logic [4*AW-1:0]   cell_addr;
  logic [31:0]       cell_din, cell_dout;
  logic [3:0]        cell_wen, cell_sense_en;

  logic              fa_gnt, fb_gnt, fa_rvalid, fb_rvalid, fa_wdone, fb_wdone;
  logic [31:0]       f_rdata, f_cell_din;
  logic              f_busy;
  logic [4*AW-1:0]   f_cell_addr;
  logic [3:0]        f_cell_wen, f_cell_sense_en;
  logic [31:0]       f_cell_dout;

  logic [1:0] gnt, rvalid, wdone, fp_gnt;
  assign gnt    = {b_gnt, a_gnt};
  assign rvalid = {b_rvalid, a_rvalid};
  assign wdone  = {b_wdone, a_wdone};
  assign fp_gnt = {fb_gnt, fa_gnt};
  assign f_cell_dout = 32'h0;

  cache_sram_ctrl #(.ADDR_W(AW), .LANES(4), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_req(req[0]), .a_we(we[0]), .a_addr(addr[0]), .a_be(be[0]), .a_wdata(wdata[0]),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_wdone(a_wdone),
    .b_req(req[1]), .b_we(we[1]), .b_addr(addr[1]), .b_be(be[1]), .b_wdata(wdata[1]),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_wdone(b_wdone),
    .rdata(rdata), .busy(busy), .cell_addr(cell_addr), .cell_din(cell_din),
    .cell_dout(cell_dout), .cell_wen(cell_wen), .cell_sense_en(cell_sense_en)
  );

  cache_sram_ctrl #(.ADDR_W(AW), .LANES(4), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .a_req(req[0]), .a_we(we[0]), .a_addr(addr[0]), .a_be(be[0]), .a_wdata(wdata[0]),
    .a_gnt(fa_gnt), .a_rvalid(fa_rvalid), .a_wdone(fa_wdone),
    .b_req(req[1]), .b_we(we[1]), .b_addr(addr[1]), .b_be(be[1]), .b_wdata(wdata[1]),
    .b_gnt(fb_gnt), .b_rvalid(fb_rvalid), .b_wdone(fb_wdone),
    .rdata(f_rdata), .busy(f_busy), .cell_addr(f_cell_addr), .cell_din(f_cell_din),
    .cell_dout(f_cell_dout), .cell_wen(f_cell_wen), .cell_sense_en(f_cell_sense_en)
  );

  // Behavioural SRAM cells: write on clock edge, combinational sensed output.
  logic [7:0] sram [4][512];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (cell_wen[i]) sram[i][cell_addr[i*AW +: AW]] <= cell_din[8*i +: 8];
  end
  always_comb begin
    cell_dout = '0;
    for (int i = 0; i < 4; i++)
      if (cell_sense_en[i]) cell_dout[8*i +: 8] = sram[i][cell_addr[i*AW +: AW]];
  end

  // Word-level reference memory and scoreboard.
  logic [31:0] ref_mem [512];
  typedef struct {
    logic        port;
    logic        wr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  bit fp_chk = 0;
  int fp_cnt = 0;

  // Monitor and model: pop responses, check lane exclusivity, predict grants.
  initial begin
    int   next_free;
    logic m_last;
    next_free = 0;
    m_last    = 1'b1;
    for (int i = 0; i < 512; i++) begin
      ref_mem[i] = 32'h0;
      for (int l = 0; l < 4; l++) sram[l][i] = 8'h00;
    end
    forever begin
      @(negedge clk);
      if (rvalid != 2'b00 || wdone != 2'b00) begin
        if (sb.size() == 0) begin
          check("resp_unexpected", {60'h0, rvalid, wdone}, 64'h0);
        end else begin
          exp_t e;
          logic [1:0] oh;
          e  = sb.pop_front();
          oh = e.port ? 2'b10 : 2'b01;
          check("resp_kind", {60'h0, rvalid, wdone}, e.wr ? {62'h0, oh} : {60'h0, oh, 2'b00});
          if (!e.wr) check("rdata", rdata, e.data);
        end
      end
      if (cell_wen != 4'h0 || cell_sense_en != 4'h0)
        check("wen_sense_excl", (cell_wen != 4'h0) && (cell_sense_en != 4'h0), 0);
      if (fp_chk && fp_gnt != 2'b00) begin
        check("fp_gnt_b", fp_gnt, 2'b10);
        fp_cnt++;
      end
      if (rst) begin
        sb.delete();
        next_free = cyc + 1;
        m_last    = 1'b1;
        if (req != 2'b00) check("gnt_in_rst", gnt, 2'b00);
      end else if (req != 2'b00 || gnt != 2'b00) begin
        logic [1:0] exp_g;
        exp_g = 2'b00;
        if (cyc >= next_free) begin
          if (req == 2'b11) exp_g = m_last ? 2'b01 : 2'b10;
          else exp_g = req;
        end
        check("grant", gnt, exp_g);
        if (exp_g != 2'b00) begin
          exp_t e;
          int   p;
          p = exp_g[1] ? 1 : 0;
          m_last    = exp_g[1];
          next_free = cyc + 3;
          e.port = exp_g[1];
          e.wr   = we[p];
          e.data = ref_mem[addr[p]];
          if (we[p]) begin
            for (int l = 0; l < 4; l++)
              if (be[p][l]) ref_mem[addr[p]][8*l +: 8] = wdata[p][8*l +: 8];
          end
          sb.push_back(e);
        end
      end
    end
  end

  // Randomized requester: hold req until granted, then drop it.
  task automatic drive_req(int p, logic w, logic [AW-1:0] a, logic [3:0] b, logic [31:0] d);
    int k;
    @(posedge clk); #1;
    we[p] = w; addr[p] = a; be[p] = b; wdata[p] = d; req[p] = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (gnt[p]) break;
      k++;
      if (k > 60) begin
        check("gnt_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  // Directed access with per-cycle phase checks (port idle when issued).
  task automatic dir_access(int p, logic w, logic [AW-1:0] a, logic [3:0] b,
                            logic [31:0] d, logic [31:0] expd);
    logic [1:0] oh;
    oh = (p == 0) ? 2'b01 : 2'b10;
    @(posedge clk); #1;
    we[p] = w; addr[p] = a; be[p] = b; wdata[p] = d; req[p] = 1'b1;
    @(negedge clk);
    check("dir_gnt", gnt, oh);
    @(posedge clk); #1;
    req[p] = 1'b0;
    @(negedge clk);
    check("t1_busy", busy, 1);
    check("t1_addr", cell_addr, {4{a}});
    if (w) begin
      check("t1_wen", cell_wen, b);
      check("t1_din", cell_din, d);
    end else begin
      check("t1_sense", cell_sense_en, 4'h0);
    end
    @(negedge clk);
    if (w) begin
      check("t2_wen", cell_wen, 4'h0);
      check("t2_wdone", wdone, oh);
      check("t2_din_hold", cell_din, d);
    end else begin
      check("t2_sense", cell_sense_en, 4'hF);
      check("t2_rvalid", rvalid, 2'b00);
    end
    @(negedge clk);
    check("t3_busy", busy, 0);
    if (w) begin
      check("t3_wdone", wdone, 2'b00);
    end else begin
      check("t3_rvalid", rvalid, oh);
      check("t3_rdata", rdata, expd);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] gseq [$];
    int         gcyc [$];
    req = 2'b00; we = 2'b00;
    for (int p = 0; p < 2; p++) begin
      addr[p] = '0; be[p] = 4'h0; wdata[p] = 32'h0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_wen", cell_wen, 4'h0);
    check("rst_sense", cell_sense_en, 4'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_resp", {rvalid, wdone}, 4'h0);
    check("rst_addr", cell_addr, 36'h0);
    check("rst_din", cell_din, 32'h0);

    // Both ports requesting from reset: round-robin vs fixed B priority.
    we = 2'b00; addr[0] = 9'h005; addr[1] = 9'h006; req = 2'b11;
    fp_chk = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        gseq.push_back(gnt);
        gcyc.push_back(cyc);
      end
    end
    @(posedge clk); #1;
    req = 2'b00;
    fp_chk = 0;
    check("rr_count", gseq.size(), 4);
    for (int i = 0; i < gseq.size(); i++) begin
      check("rr_order", gseq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) check("rr_spacing", gcyc[i] - gcyc[i-1], 3);
    end
    check("fp_count", fp_cnt, 4);
    repeat (4) @(posedge clk);

    // Full write and readback; partial write; be=0; top address.
    dir_access(0, 1'b1, 9'h005, 4'hF, 32'hDEADBEEF, 32'h0);
    dir_access(0, 1'b0, 9'h005, 4'h0, 32'h0, 32'hDEADBEEF);
    dir_access(0, 1'b1, 9'h010, 4'hF, 32'h11223344, 32'h0);
    dir_access(1, 1'b1, 9'h010, 4'b0010, 32'h0000AA00, 32'h0);
    dir_access(0, 1'b0, 9'h010, 4'h0, 32'h0, 32'h1122AA44);
    dir_access(1, 1'b1, 9'h010, 4'h0, 32'hFFFFFFFF, 32'h0);
    dir_access(1, 1'b0, 9'h010, 4'h0, 32'h0, 32'h1122AA44);
    dir_access(0, 1'b1, 9'h1FF, 4'hF, 32'hCAFEF00D, 32'h0);
    dir_access(1, 1'b1, 9'h000, 4'hF, 32'h0BADC0DE, 32'h0);
    dir_access(0, 1'b0, 9'h000, 4'h0, 32'h0, 32'h0BADC0DE);
    dir_access(1, 1'b0, 9'h1FF, 4'h0, 32'h0, 32'hCAFEF00D);

    // B request arriving during RD_SENSE of an A read waits for T+3.
    @(posedge clk); #1;
    we[0] = 1'b0; addr[0] = 9'h1FF; req[0] = 1'b1;
    @(negedge clk);
    check("t4_a_gnt", gnt, 2'b01);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    we[1] = 1'b0; addr[1] = 9'h005; req[1] = 1'b1;
    @(negedge clk);
    check("t4_no_gnt_sense", gnt, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_b_gnt_t3", gnt, 2'b10);
    check("t4_a_rvalid", rvalid, 2'b01);
    @(posedge clk); #1;
    req[1] = 1'b0;
    repeat (4) @(posedge clk);

    // Reset during the WR cycle kills the pending wdone.
    @(posedge clk); #1;
    we[0] = 1'b1; addr[0] = 9'h030; be[0] = 4'hF; wdata[0] = 32'h55AA55AA; req[0] = 1'b1;
    @(negedge clk);
    check("t5_gnt", gnt, 2'b01);
    @(posedge clk); #1;
    req[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t5_wr_wen", cell_wen, 4'hF);
    @(posedge clk); #1;
    rst = 1'b0;
    we[0] = 1'b0; req[0] = 1'b1;
    @(negedge clk);
    check("t5_wen_clr", cell_wen, 4'h0);
    check("t5_busy_clr", busy, 0);
    check("t5_no_wdone", wdone, 2'b00);
    check("t5_gnt_after", gnt, 2'b01);
    @(posedge clk); #1;
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_no_wdone_late", wdone, 2'b00);
    repeat (4) @(posedge clk);

    // Random traffic from both ports concurrently.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [AW-1:0] ra;
          ra = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 7));
          drive_req(0, 1'($urandom_range(0, 1)), ra, 4'($urandom), $urandom);
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          logic [AW-1:0] rb;
          rb = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 7));
          drive_req(1, 1'($urandom_range(0, 1)), rb, 4'($urandom), $urandom);
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
    join
    repeat (10) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
